// File: rtl/softmax_pkg.sv
// Shared widths, FSM state encoding and the exp-value decoder for the softmax
// normaliser.
package softmax_pkg;

    localparam int EXP_W  = 21;
    localparam int POS_W  = 5;
    localparam int MANT_W = 16;
    localparam int DEC_W  = 47;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_LOAD    = 2'd1,
        ST_DIV     = 2'd2,
        ST_OUT     = 2'd3
    } state_e;

    // An exp value is a mantissa shifted left by an unsigned position.
    function automatic logic [DEC_W-1:0] decode_exp(input logic [EXP_W-1:0] x);
        logic [DEC_W-1:0] mant;
        mant = DEC_W'(x[MANT_W-1:0]);
        return mant << x[MANT_W +: POS_W];
    endfunction

endpackage

// File: rtl/softmax_norm_if.sv
// Stream interface of the softmax normaliser: exp values in, probabilities out.
interface softmax_norm_if #(
    parameter int Q_W = 16
);
    import softmax_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [EXP_W-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [Q_W-1:0]   out_data;
    logic             out_last;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

endinterface

// File: rtl/softmax_div.sv
// Restoring divider producing dividend/divisor as a Q_W-bit fraction, one
// quotient bit per cycle, MSB first.
module softmax_div #(
    parameter int Q_W   = 16,
    parameter int SUM_W = 49
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [SUM_W-1:0] dividend,
    input  logic [SUM_W-1:0] divisor,
    output logic             done,
    output logic [Q_W-1:0]   quotient
);

    localparam int IT_W = (Q_W > 1) ? $clog2(Q_W) : 1;

    logic [SUM_W-1:0] rem_reg;
    logic [SUM_W-1:0] rem_next;
    logic [Q_W-1:0]   quo_reg;
    logic [IT_W-1:0]  iter_reg;
    logic             busy_reg;
    logic             sat_reg;
    logic [SUM_W:0]   rem_dbl;
    logic             q_bit;

    // A zero divisor must yield zero bits, otherwise every compare would succeed.
    assign rem_dbl  = {rem_reg, 1'b0};
    assign q_bit    = (divisor != '0) && (rem_dbl >= {1'b0, divisor});
    assign rem_next = q_bit ? SUM_W'(rem_dbl - {1'b0, divisor}) : rem_dbl[SUM_W-1:0];

    assign done     = busy_reg && (iter_reg == IT_W'(Q_W - 1));
    assign quotient = sat_reg ? '1 : quo_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_reg  <= '0;
            quo_reg  <= '0;
            iter_reg <= '0;
            busy_reg <= 1'b0;
            sat_reg  <= 1'b0;
        end else if (start) begin
            rem_reg  <= dividend;
            quo_reg  <= '0;
            iter_reg <= '0;
            busy_reg <= 1'b1;
            // A lone non-zero element is probability 1.0, clamped to all ones.
            sat_reg  <= (dividend == divisor) && (divisor != '0);
        end else if (busy_reg) begin
            rem_reg  <= rem_next;
            quo_reg  <= {quo_reg[Q_W-2:0], q_bit};
            iter_reg <= iter_reg + 1'b1;
            if (done) begin
                busy_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/softmax_norm.sv
// Softmax normaliser: buffers N exp values while summing them, then emits each
// value divided by the sum as an unsigned Q_W-bit fraction.
module softmax_norm
    import softmax_pkg::*;
#(
    parameter int N   = 4,
    parameter int Q_W = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    softmax_norm_if.slave bus
);

    localparam int SUM_W = DEC_W + $clog2(N);
    localparam int IDX_W = $clog2(N);

    localparam logic [1:0] S_COLLECT = ST_COLLECT;
    localparam logic [1:0] S_LOAD    = ST_LOAD;
    localparam logic [1:0] S_DIV     = ST_DIV;
    localparam logic [1:0] S_OUT     = ST_OUT;

    logic [1:0]       state_reg, state_next;
    logic [IDX_W-1:0] cnt_reg, cnt_next;
    logic [IDX_W-1:0] e_reg, e_next;
    logic [SUM_W-1:0] sum_reg, sum_next;

    logic [EXP_W-1:0] buffer [N];
    logic [EXP_W-1:0] rd_data_reg;

    logic             accept;
    logic             last_elem;
    logic             div_start;
    logic             div_done;
    logic [Q_W-1:0]   div_q;
    logic [SUM_W-1:0] dividend;

    assign accept    = (state_reg == S_COLLECT) && bus.in_valid;
    assign last_elem = (e_reg == IDX_W'(N - 1));
    assign dividend  = SUM_W'(decode_exp(rd_data_reg));

    assign bus.in_ready  = (state_reg == S_COLLECT);
    assign bus.out_valid = (state_reg == S_OUT);
    assign bus.out_last  = (state_reg == S_OUT) && last_elem;
    assign bus.out_data  = (state_reg == S_OUT) ? div_q : '0;

    // Reading at the next element index lets LOAD see buffer[e] registered.
    always_ff @(posedge clk) begin
        if (accept) begin
            buffer[cnt_reg] <= bus.in_data;
        end
        rd_data_reg <= buffer[e_next];
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        e_next     = e_reg;
        sum_next   = sum_reg;
        div_start  = 1'b0;
        case (state_reg)
            S_COLLECT: begin
                if (accept) begin
                    sum_next = sum_reg + SUM_W'(decode_exp(bus.in_data));
                    if (cnt_reg == IDX_W'(N - 1)) begin
                        e_next     = '0;
                        state_next = S_LOAD;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            S_LOAD: begin
                div_start  = 1'b1;
                state_next = S_DIV;
            end
            S_DIV: begin
                if (div_done) begin
                    state_next = S_OUT;
                end
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    if (!last_elem) begin
                        e_next     = e_reg + 1'b1;
                        state_next = S_LOAD;
                    end else begin
                        cnt_next   = '0;
                        sum_next   = '0;
                        e_next     = '0;
                        state_next = S_COLLECT;
                    end
                end
            end
            default: begin
                state_next = S_COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_COLLECT;
            cnt_reg   <= '0;
            e_reg     <= '0;
            sum_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            e_reg     <= e_next;
            sum_reg   <= sum_next;
        end
    end

    softmax_div #(
        .Q_W   (Q_W),
        .SUM_W (SUM_W)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (dividend),
        .divisor  (sum_reg),
        .done     (div_done),
        .quotient (div_q)
    );

endmodule

// File: tb/tb_softmax_norm.sv
// Directed self-checking bench for softmax_norm (N=4, Q_W=16).
module tb_softmax_norm;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   ref_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    softmax_norm_if #(.Q_W(16)) bus ();

    softmax_norm #(
        .N   (4),
        .Q_W (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [20:0] ev(input int p, input int m);
        return {5'(p), 16'(m)};
    endfunction

    // Drives four exp values; optional idle gaps carry junk data with in_valid low.
    task automatic send4(input logic [20:0] a, input logic [20:0] b,
                         input logic [20:0] c, input logic [20:0] d, input bit gaps);
        logic [20:0] v [4];
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        for (int i = 0; i < 4; i++) begin
            int w = 0;
            while (bus.in_ready !== 1'b1 && w < 40) begin
                @(posedge clk); #1; w++;
            end
            bus.in_data  = v[i];
            bus.in_valid = 1'b1;
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            if (gaps && i < 3) begin
                bus.in_data = ev(5, 16'hFFFF);
                @(posedge clk); #1;
            end
        end
        ref_cyc = cyc;
    endtask

    task automatic wait_out(output int lat, output bit ok);
        int w = 0;
        while (bus.out_valid !== 1'b1 && w < 40) begin
            @(posedge clk); #1; w++;
        end
        ok  = (bus.out_valid === 1'b1);
        lat = cyc - ref_cyc;
    endtask

    task automatic pop();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        ref_cyc = cyc;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        total++; if (bus.out_data !== 16'h0) begin bad++; $display("FAIL reset_out_data: got %h want 0000", bus.out_data); end
        total++; if (bus.out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last: got %b want 0", bus.out_last); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready: got %b want 1", bus.in_ready); end
        $display("reset: in_ready=%b out_valid=%b", bus.in_ready, bus.out_valid);
    endtask

    task automatic test_equal();
        logic [15:0] exp_d [4] = '{16'h4000, 16'h4000, 16'h4000, 16'h4000};
        int lat; bit ok;
        send4(ev(0, 'h8000), ev(0, 'h8000), ev(0, 'h8000), ev(0, 'h8000), 1'b0);
        for (int i = 0; i < 4; i++) begin
            wait_out(lat, ok);
            $display("equal[%0d]: data=%h last=%b lat=%0d", i, bus.out_data, bus.out_last, lat);
            total++; if (!ok || lat != 17) begin bad++; $display("FAIL equal_lat[%0d]: got %0d want 17", i, lat); end
            total++; if (bus.out_data !== exp_d[i]) begin bad++; $display("FAIL equal_data[%0d]: got %h want %h", i, bus.out_data, exp_d[i]); end
            total++; if (bus.out_last !== (i == 3)) begin bad++; $display("FAIL equal_last[%0d]: got %b want %b", i, bus.out_last, (i == 3)); end
            pop();
            total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL equal_drop[%0d]: out_valid %b want 0", i, bus.out_valid); end
        end
    endtask

    task automatic test_mixed();
        logic [15:0] exp_d [4] = '{16'h6666, 16'h3333, 16'h3333, 16'h3333};
        int lat; bit ok;
        send4(ev(1, 'h8000), ev(0, 'h8000), ev(0, 'h8000), ev(0, 'h8000), 1'b0);
        for (int i = 0; i < 4; i++) begin
            wait_out(lat, ok);
            $display("mixed[%0d]: data=%h last=%b lat=%0d", i, bus.out_data, bus.out_last, lat);
            total++; if (!ok || lat != 17) begin bad++; $display("FAIL mixed_lat[%0d]: got %0d want 17", i, lat); end
            total++; if (bus.out_data !== exp_d[i]) begin bad++; $display("FAIL mixed_data[%0d]: got %h want %h", i, bus.out_data, exp_d[i]); end
            total++; if (bus.out_last !== (i == 3)) begin bad++; $display("FAIL mixed_last[%0d]: got %b want %b", i, bus.out_last, (i == 3)); end
            pop();
        end
    endtask

    // Largest decoded values: the sum needs the two guard bits above 47.
    task automatic test_max_position();
        int lat; bit ok;
        send4(ev(31, 'hFFFF), ev(31, 'hFFFF), ev(31, 'hFFFF), ev(31, 'hFFFF), 1'b0);
        for (int i = 0; i < 4; i++) begin
            wait_out(lat, ok);
            $display("maxpos[%0d]: data=%h last=%b lat=%0d", i, bus.out_data, bus.out_last, lat);
            total++; if (!ok || bus.out_data !== 16'h4000) begin bad++; $display("FAIL maxpos_data[%0d]: got %h want 4000", i, bus.out_data); end
            pop();
        end
    endtask

    task automatic test_onehot();
        logic [15:0] exp_d [4] = '{16'hFFFF, 16'h0000, 16'h0000, 16'h0000};
        int lat; bit ok;
        send4(ev(3, 'h1234), ev(0, 0), ev(0, 0), ev(0, 0), 1'b0);
        for (int i = 0; i < 4; i++) begin
            wait_out(lat, ok);
            $display("onehot[%0d]: data=%h last=%b lat=%0d", i, bus.out_data, bus.out_last, lat);
            total++; if (!ok || lat != 17) begin bad++; $display("FAIL onehot_lat[%0d]: got %0d want 17", i, lat); end
            total++; if (bus.out_data !== exp_d[i]) begin bad++; $display("FAIL onehot_data[%0d]: got %h want %h", i, bus.out_data, exp_d[i]); end
            pop();
        end
    endtask

    task automatic test_zero_sum();
        int lat; bit ok;
        send4(ev(0, 0), ev(0, 0), ev(0, 0), ev(0, 0), 1'b0);
        for (int i = 0; i < 4; i++) begin
            wait_out(lat, ok);
            $display("zero[%0d]: data=%h last=%b lat=%0d", i, bus.out_data, bus.out_last, lat);
            total++; if (!ok || lat != 17) begin bad++; $display("FAIL zero_lat[%0d]: got %0d want 17", i, lat); end
            total++; if (bus.out_data !== 16'h0000) begin bad++; $display("FAIL zero_data[%0d]: got %h want 0000", i, bus.out_data); end
            total++; if (bus.out_last !== (i == 3)) begin bad++; $display("FAIL zero_last[%0d]: got %b want %b", i, bus.out_last, (i == 3)); end
            pop();
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] exp_d [4] = '{16'h6666, 16'h3333, 16'h3333, 16'h3333};
        int lat; bit ok;
        send4(ev(1, 'h8000), ev(0, 'h8000), ev(0, 'h8000), ev(0, 'h8000), 1'b0);
        for (int i = 0; i < 4; i++) begin
            wait_out(lat, ok);
            $display("bp[%0d]: data=%h last=%b lat=%0d", i, bus.out_data, bus.out_last, lat);
            total++; if (!ok || lat != 17) begin bad++; $display("FAIL bp_lat[%0d]: got %0d want 17", i, lat); end
            if (i == 1) begin
                // Junk offered while stalled must be ignored.
                bus.in_valid = 1'b1;
                bus.in_data  = ev(9, 'hABCD);
                for (int k = 0; k < 5; k++) begin
                    @(posedge clk); #1;
                    $display("bp stall %0d: valid=%b data=%h last=%b in_ready=%b", k, bus.out_valid, bus.out_data, bus.out_last, bus.in_ready);
                    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", k, bus.out_valid); end
                    total++; if (bus.out_data !== 16'h3333) begin bad++; $display("FAIL bp_hold_data[%0d]: got %h want 3333", k, bus.out_data); end
                    total++; if (bus.out_last !== 1'b0) begin bad++; $display("FAIL bp_hold_last[%0d]: got %b want 0", k, bus.out_last); end
                    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d]: got %b want 0", k, bus.in_ready); end
                end
                bus.in_valid = 1'b0;
            end
            total++; if (bus.out_data !== exp_d[i]) begin bad++; $display("FAIL bp_data[%0d]: got %h want %h", i, bus.out_data, exp_d[i]); end
            total++; if (bus.out_last !== (i == 3)) begin bad++; $display("FAIL bp_last[%0d]: got %b want %b", i, bus.out_last, (i == 3)); end
            pop();
        end
    endtask

    task automatic test_input_gaps();
        logic [15:0] exp_d [4] = '{16'h3333, 16'h3333, 16'h6666, 16'h3333};
        int lat; bit ok;
        send4(ev(0, 'h8000), ev(0, 'h8000), ev(1, 'h8000), ev(0, 'h8000), 1'b1);
        bus.in_valid = 1'b1;
        bus.in_data  = ev(7, 'h7777);
        for (int i = 0; i < 4; i++) begin
            wait_out(lat, ok);
            bus.in_valid = 1'b0;
            $display("gaps[%0d]: data=%h last=%b lat=%0d", i, bus.out_data, bus.out_last, lat);
            total++; if (!ok || lat != 17) begin bad++; $display("FAIL gaps_lat[%0d]: got %0d want 17", i, lat); end
            total++; if (bus.out_data !== exp_d[i]) begin bad++; $display("FAIL gaps_data[%0d]: got %h want %h", i, bus.out_data, exp_d[i]); end
            pop();
        end
    endtask

    task automatic test_reset_mid_div();
        int lat; bit ok;
        send4(ev(1, 'h8000), ev(0, 'h8000), ev(0, 'h8000), ev(0, 'h8000), 1'b0);
        wait_out(lat, ok);
        total++; if (!ok || bus.out_data !== 16'h6666) begin bad++; $display("FAIL rst_pre_data: got %h want 6666", bus.out_data); end
        pop();
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        $display("reset mid-div: in_ready=%b out_valid=%b data=%h last=%b", bus.in_ready, bus.out_valid, bus.out_data, bus.out_last);
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_in_ready: got %b want 1", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_out_valid: got %b want 0", bus.out_valid); end
        total++; if (bus.out_data !== 16'h0) begin bad++; $display("FAIL rst_mid_out_data: got %h want 0000", bus.out_data); end
        total++; if (bus.out_last !== 1'b0) begin bad++; $display("FAIL rst_mid_out_last: got %b want 0", bus.out_last); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send4(ev(0, 'h8000), ev(0, 'h8000), ev(0, 'h8000), ev(0, 'h8000), 1'b0);
        for (int i = 0; i < 4; i++) begin
            wait_out(lat, ok);
            $display("after_rst[%0d]: data=%h last=%b lat=%0d", i, bus.out_data, bus.out_last, lat);
            total++; if (!ok || lat != 17) begin bad++; $display("FAIL after_rst_lat[%0d]: got %0d want 17", i, lat); end
            total++; if (bus.out_data !== 16'h4000) begin bad++; $display("FAIL after_rst_data[%0d]: got %h want 4000", i, bus.out_data); end
            total++; if (bus.out_last !== (i == 3)) begin bad++; $display("FAIL after_rst_last[%0d]: got %b want %b", i, bus.out_last, (i == 3)); end
            pop();
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_equal();
        test_mixed();
        test_max_position();
        test_onehot();
        test_zero_sum();
        test_backpressure();
        test_input_gaps();
        test_reset_mid_div();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/softmax_norm.md
SOFTMAX_NORM -- requirements
Module: softmax_norm

Interface
REQ-001 Parameter N, default 4, is the number of exp values per softmax vector; N is between 2 and 16.
REQ-002 Parameter Q_W, default 16, is the output probability width in fraction bits.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 in_valid  input  1  in_data carries a valid exp value.
REQ-006 in_ready  output  1  block accepts in_data this cycle.
REQ-007 in_data  input  21  exp value in the exp-unit format: [20:16] position P (unsigned), [15:0] mantissa M.
REQ-008 out_valid  output  1  out_data carries a normalized probability.
REQ-009 out_ready  input  1  downstream accepts out_data this cycle.
REQ-010 out_data  output  Q_W  probability, unsigned fraction, value = out_data / 2^Q_W.
REQ-011 out_last  output  1  high with out_valid on the Nth output of a vector.

Function
REQ-012 Each input SHALL decode to D = M << P, an unsigned 47-bit integer.
REQ-013 The sum accumulator SHALL be 47 + ceil(log2 N) bits wide and SHALL never overflow.
REQ-014 States SHALL be COLLECT, LOAD, DIV and OUT.
REQ-015 COLLECT: in_ready = 1; each in_valid&in_ready edge stores raw in_data at buffer[cnt], adds D to SUM, and increments cnt.
REQ-016 The accept at cnt = N-1 SHALL move the block to LOAD with element index e = 0.
REQ-017 LOAD (1 cycle): remainder R <= D(buffer[e]), quotient Q <= 0, iteration counter <= 0, then DIV.
REQ-018 DIV: exactly Q_W cycles of restoring division, one quotient bit per cycle: R2 = R<<1; if R2 >= SUM then R <= R2-SUM and Q bit = 1, else R <= R2 and Q bit = 0; MSB first.
REQ-019 After the Q_W-th DIV cycle the block SHALL move to OUT with out_data = Q.
REQ-020 Latency: out_valid SHALL rise exactly 1 + Q_W cycles (17 at default) after the edge that accepted the final input, and the same count after each out handshake that is not the last.
REQ-021 OUT: out_valid = 1; out_data and out_last SHALL be held stable until out_valid&out_ready.
REQ-022 On the OUT handshake, if e < N-1 then e++ and go to LOAD; else clear cnt and SUM and go to COLLECT.
REQ-023 Saturation: if D(buffer[e]) == SUM and SUM != 0, out_data SHALL be 2^Q_W - 1.
REQ-024 Zero sum: if SUM == 0, every out_data SHALL be 0; the cycle count per element is unchanged.
REQ-025 in_ready SHALL be 0 in LOAD, DIV and OUT; in_data presented then is ignored.
REQ-026 out_valid SHALL be 0 in every state except OUT.
REQ-027 out_last SHALL be 1 only in OUT with e == N-1.

Reset
REQ-028 rst_n low SHALL immediately force: state COLLECT, cnt 0, e 0, SUM 0, R 0, Q 0, out_valid 0, out_data 0, out_last 0.
REQ-029 in_ready SHALL equal 1 while in reset.
REQ-030 Reset asserted mid-vector, in any state, SHALL discard the partial vector; the first accept after release is element 0 of a new vector.
REQ-031 The buffer contents need no reset.

Structure
REQ-032 Package softmax_pkg SHALL hold:
- EXP_W = 21, POS_W = 5, MANT_W = 16, DEC_W = 47
- the state enum
- a decode function implementing REQ-012
REQ-033 The restoring-divider datapath (R, Q, iteration counter, saturation/zero handling) SHALL be a sub-module named softmax_div with start/done handshake.
REQ-034 The FSM, buffer and accumulator SHALL be in softmax_norm.

Verification
REQ-035 Equal inputs: four inputs of {P=0, M=0x8000} -> SUM 0x20000; outputs 0x4000 x4; out_last on the 4th only.
REQ-036 Mixed positions: inputs {1,0x8000} then {0,0x8000} x3 -> outputs 0x6666, 0x3333, 0x3333, 0x3333.
REQ-037 One-hot and zero sum:
- inputs {3,0x1234} then 0 x3 -> outputs 0xFFFF, 0, 0, 0
- all-zero inputs -> outputs 0 x4, each at 17-cycle spacing
REQ-038 Backpressure: out_ready low 5 cycles during OUT -> out_valid, out_data and out_last held; in_ready stays 0; the next out_valid rises 17 cycles after the handshake.
REQ-039 Reset mid-DIV: pulse rst_n low during element 1's DIV -> all outputs 0 at once, in_ready 1; a fresh vector then completes correctly.
REQ-040 Input gaps: in_valid toggling 1/0 during COLLECT -> only handshaked values are stored; the first out_valid rises 17 cycles after the 4th accept.
